// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, NZCV flags and illegal-op pulse.
// Optional macro ALU_MUL_EN builds the iterative shift-add multiplier (opcode 10).
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  input  logic             set_flags,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             out_valid,
  output logic             err
);

  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [3:0] OpAnd = 4'd0;
  localparam logic [3:0] OpOrr = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpMov = 4'd4;
  localparam logic [3:0] OpEor = 4'd5;
  localparam logic [3:0] OpLsl = 4'd6;
  localparam logic [3:0] OpLsr = 4'd7;
  localparam logic [3:0] OpAsr = 4'd8;
  localparam logic [3:0] OpCmp = 4'd9;

  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;
  logic             err_q;

  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  logic             mul_sf;

  assign accept = in_valid && in_ready;

  // Single-cycle datapath; the extra bit carries the carry/borrow or the last bit shifted out.
  logic [WIDTH:0]   sum, diff, shl, shr, sar;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_n, sc_z, sc_c, sc_v;
  logic             sc_wr_res, sc_legal;

  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shl   = {1'b0, a} << shamt;
  assign shr   = {a, 1'b0} >> shamt;
  assign sar   = $unsigned($signed({a, 1'b0}) >>> shamt);

  always_comb begin
    sc_res    = result_q;
    sc_c      = flags_q[1];
    sc_v      = flags_q[0];
    sc_wr_res = 1'b1;
    sc_legal  = 1'b1;
    case (ALUOp)
      OpAnd: sc_res = a & b;
      OpOrr: sc_res = a | b;
      OpEor: sc_res = a ^ b;
      OpMov: sc_res = b;
      OpAdd: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
      end
      OpSub, OpCmp: begin
        sc_res    = diff[WIDTH-1:0];
        sc_c      = ~diff[WIDTH];
        sc_v      = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
        sc_wr_res = (ALUOp == OpSub);
      end
      OpLsl: begin
        sc_res = shl[WIDTH-1:0];
        if (shamt != '0) sc_c = shl[WIDTH];
      end
      OpLsr: begin
        sc_res = shr[WIDTH:1];
        if (shamt != '0) sc_c = shr[0];
      end
      OpAsr: begin
        sc_res = sar[WIDTH:1];
        if (shamt != '0) sc_c = sar[0];
      end
`ifdef ALU_MUL_EN
      4'd10: sc_wr_res = 1'b0;
`endif
      default: begin
        sc_legal  = 1'b0;
        sc_wr_res = 1'b0;
      end
    endcase
    sc_n = sc_res[Msb];
    sc_z = (sc_res == '0);
  end

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {StIdle, StMulRun, StMulDone} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplr_q;
  logic             mul_sf_q;

  assign is_mul = (ALUOp == 4'd10);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept && is_mul) state_d = StMulRun;
      StMulRun:  if (cnt_q == SHW'(WIDTH - 1)) state_d = StMulDone;
      StMulDone: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle);
    mul_done = (state_q == StMulDone);
  end

  // One shift-add step per cycle; acc holds the low WIDTH bits of the partial product.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      mul_sf_q <= 1'b0;
    end else if (accept && is_mul) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a;
      mplr_q   <= b;
      mul_sf_q <= set_flags;
    end else if (state_q == StMulRun) begin
      if (mplr_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign mul_res = acc_q;
  assign mul_sf  = mul_sf_q;
`else
  assign is_mul   = 1'b0;
  assign in_ready = 1'b1;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_sf   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (mul_done) begin
        out_valid_q <= 1'b1;
        result_q    <= mul_res;
        if (mul_sf) flags_q <= {mul_res[Msb], mul_res == '0, flags_q[1:0]};
      end else if (accept && !is_mul) begin
        out_valid_q <= 1'b1;
        err_q       <= ~sc_legal;
        if (sc_wr_res) result_q <= sc_res;
        if (set_flags && sc_legal) flags_q <= {sc_n, sc_z, sc_c, sc_v};
      end
    end
  end

  assign result    = result_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule
